multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Multi-cycle MIPS control unit: Moore/Mealy FSM that sequences each instruction over 3–5+ states, instead of decoding the opcode once per cycle.
- Sits between the instruction register's opcode field and the shared-memory multi-cycle datapath (PC, IR, MDR, A/B, ALUOut).
- Adds a memory ready handshake with a watchdog timeout, parametrised opcodes, retire/illegal flags and a retired-instruction counter.

Parameters:
- OP_RTYPE, 6'b000000, R-format opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_ADDI, 6'b001000, add-immediate opcode
- OP_J, 6'b000010, jump opcode (used only with CTRL_JUMP_EN)
- TIMEOUT, 64, maximum consecutive cycles a memory state waits for mem_ready (≥1)
- CNT_W, 16, width of instr_count

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- ins_opCode  in  6  opcode from IR, stable from DECODE to instruction end
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- MemtoReg  out  1  register write data select: 1=MDR
- IRWrite  out  1  IR load
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
- ALUOp  out  2  00=add, 01=sub, 10=funct
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=4, 10=signext, 11=signext<<2
- RegWrite  out  1  register file write
- RegDst  out  1  1=rd, 0=rt
- state  out  4  current state encoding
- retire  out  1  one-cycle pulse on instruction completion
- illegal_op  out  1  one-cycle pulse when DECODE sees an unknown opcode
- fault  out  1  memory timeout; sticky until rst
- instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, FAULT=15. Codes 12–14 are unreachable and go to FAULT.
- Outputs are decoded combinationally from state (plus mem_ready where noted). Any output not listed for a state is 0.
- Reset: on any rising edge with rst=1, state<=FETCH, instr_count<=0, wait counter<=0, fault<=0. While rst=1, all control outputs, retire and illegal_op are forced to 0. Reset mid-instruction abandons that instruction; no retire pulse.
- FETCH: MemRead=1, ALUSrcB=01. When mem_ready=1: IRWrite=1, PCWrite=1 in the same cycle, next state DECODE. Otherwise stay in FETCH.
- DECODE: ALUSrcB=11. Next state by opcode:
  - lw/sw -> MEMADDR
  - R-format -> EXEC
  - beq -> BRANCH
  - addi -> ADDIEX
  - anything else -> illegal_op=1, next state FETCH, no retire.
- MEMADDR: ALUSrcA=1, ALUSrcB=10. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. When mem_ready=1, next state MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1. Next state FETCH; retire=1.
- MEMWR: MemWrite=1, IorD=1. When mem_ready=1: next state FETCH, retire=1.
- EXEC: ALUSrcA=1, ALUOp=10. Next state RWB.
- RWB: RegWrite=1, RegDst=1. Next state FETCH; retire=1.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. Next state FETCH; retire=1.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next state ADDIWB.
- ADDIWB: RegWrite=1. Next state FETCH; retire=1.
- Watchdog (FETCH, MEMRD, MEMWR only):
  - Counter clears on entry to a memory state and on every cycle with mem_ready=1.
  - Increments each cycle mem_ready=0.
  - At the edge where it would reach TIMEOUT with mem_ready still 0, next state FAULT.
  - mem_ready=1 on the final allowed cycle wins: the access completes normally.
- FAULT: all control outputs 0, fault=1. Stays in FAULT until rst.
- instr_count: increments by 1 on each edge where retire=1. Holds at 2^CNT_W−1 (no wrap).
- Cycle counts with mem_ready tied high:
  - R-type 4, addi 4, beq 3, lw 5, sw 4.
  - Each memory stall cycle adds 1.

Optional Feature:
- CTRL_JUMP_EN defined:
  - DECODE with opcode OP_J -> JUMP.
  - JUMP: PCWrite=1, PCSource=10. Next state FETCH; retire=1. j takes 3 cycles.
- CTRL_JUMP_EN undefined:
  - OP_J is treated as illegal (illegal_op pulse, return to FETCH).
  - State 11 is unreachable and maps to FAULT.

Test Plan:
- rst 2 cycles, mem_ready=1, opcode 000000 -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 in state 7; retire pulse; instr_count=1.
- lw with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, IorD=1 throughout; MEMWB has MemtoReg=1, RegWrite=1; instruction total 8 cycles.
- beq, then sw -> BRANCH shows PCWriteCond=1, PCSource=01, ALUOp=01. sw MEMWR shows MemWrite=1. instr_count=2.
- opcode 111111 -> illegal_op high exactly one cycle in DECODE, next state FETCH, instr_count unchanged. Repeat with opcode 000010 with CTRL_JUMP_EN both defined (JUMP, PCSource=10, retire) and undefined (illegal_op).
- TIMEOUT=4, mem_ready held 0 in FETCH -> state=15 after 4 cycles, fault=1 and all controls 0 for 20 further cycles. rst -> FETCH, fault=0.
- rst asserted in MEMRD -> outputs 0 that cycle, state=0 next cycle, no retire, instr_count=0. CNT_W=2 with 5 instructions -> instr_count saturates at 3.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control unit.
// Sequences each instruction over several states and drives the shared-memory
// datapath controls. Memory states wait on mem_ready under a watchdog that
// parks the FSM in FAULT until reset. Retired instructions are counted with
// a saturating counter.
// Optional feature: define CTRL_JUMP_EN to decode OP_J into the JUMP state;
// without it OP_J is reported as an illegal opcode.
module multicycle_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter int         TIMEOUT  = 64,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       ins_opCode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [3:0]       state,
    output logic             retire,
    output logic             illegal_op,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADDR = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        FAULT   = 4'd15
    } stateType;

    // The wait counter only ever holds 0..TIMEOUT-1: at TIMEOUT-1 a further
    // idle cycle exits to FAULT instead of incrementing.
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    stateType          stateReg, stateNext;
    logic [WAIT_W-1:0] waitReg, waitNext;
    logic              faultReg;
    logic [CNT_W-1:0]  countReg;
    logic              waitExpired;

    // Memory stalled on the last cycle the watchdog allows.
    assign waitExpired = !mem_ready && (waitReg == WAIT_LAST);

    // State, watchdog, sticky fault flag and saturating retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= FETCH;
            waitReg  <= '0;
            faultReg <= 1'b0;
            countReg <= '0;
        end else begin
            stateReg <= stateNext;
            waitReg  <= waitNext;
            if (stateNext == FAULT) begin
                faultReg <= 1'b1;
            end
            if (retire && (countReg != {CNT_W{1'b1}})) begin
                countReg <= countReg + CNT_W'(1);
            end
        end
    end

    // Next-state and control decode; outputs are forced low while in reset.
    always_comb begin
        stateNext   = stateReg;
        waitNext    = '0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        retire      = 1'b0;
        illegal_op  = 1'b0;

        case (stateReg)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    stateNext = DECODE;
                end else if (waitExpired) begin
                    stateNext = FAULT;
                end else begin
                    waitNext = waitReg + WAIT_W'(1);
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                if ((ins_opCode == OP_LW) || (ins_opCode == OP_SW)) begin
                    stateNext = MEMADDR;
                end else if (ins_opCode == OP_RTYPE) begin
                    stateNext = EXEC;
                end else if (ins_opCode == OP_BEQ) begin
                    stateNext = BRANCH;
                end else if (ins_opCode == OP_ADDI) begin
                    stateNext = ADDIEX;
`ifdef CTRL_JUMP_EN
                end else if (ins_opCode == OP_J) begin
                    stateNext = JUMP;
`else
                end else if (ins_opCode == OP_J) begin
                    // Jump support is compiled out: j is just another bad opcode.
                    illegal_op = 1'b1;
                    stateNext  = FETCH;
`endif
                end else begin
                    illegal_op = 1'b1;
                    stateNext  = FETCH;
                end
            end
            MEMADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                stateNext = (ins_opCode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    stateNext = MEMWB;
                end else if (waitExpired) begin
                    stateNext = FAULT;
                end else begin
                    waitNext = waitReg + WAIT_W'(1);
                end
            end
            MEMWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                retire    = 1'b1;
                stateNext = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    stateNext = FETCH;
                end else if (waitExpired) begin
                    stateNext = FAULT;
                end else begin
                    waitNext = waitReg + WAIT_W'(1);
                end
            end
            EXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                stateNext = RWB;
            end
            RWB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                retire    = 1'b1;
                stateNext = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
                stateNext   = FETCH;
            end
            ADDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                stateNext = ADDIWB;
            end
            ADDIWB: begin
                RegWrite  = 1'b1;
                retire    = 1'b1;
                stateNext = FETCH;
            end
`ifdef CTRL_JUMP_EN
            JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                retire    = 1'b1;
                stateNext = FETCH;
            end
`endif
            FAULT: begin
                stateNext = FAULT;
            end
            default: begin
                // Unused encodings can only come from an upset; park safely.
                stateNext = FAULT;
            end
        endcase

        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            PCSource    = 2'b00;
            ALUOp       = 2'b00;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            retire      = 1'b0;
            illegal_op  = 1'b0;
        end
    end

    assign state       = stateReg;
    assign fault       = faultReg;
    assign instr_count = countReg;

endmodule
